// File: rtl/dram_ld_unit_pkg.sv
// Shared definitions for the DRAM load unit: load-select encodings (funct3), FSM states, helpers.
package dram_ld_unit_pkg;

  localparam logic [2:0] DRAM_RD_B  = 3'b000;
  localparam logic [2:0] DRAM_RD_H  = 3'b001;
  localparam logic [2:0] DRAM_RD_W  = 3'b010;
  localparam logic [2:0] DRAM_RD_BU = 3'b100;
  localparam logic [2:0] DRAM_RD_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2,
    DONE = 2'd3
  } ld_state_e;

  function automatic logic sel_is_half(input logic [2:0] sel);
    return (sel == DRAM_RD_H) || (sel == DRAM_RD_HU);
  endfunction

  function automatic logic sel_is_illegal(input logic [2:0] sel);
    return (sel == 3'b011) || (sel == 3'b110) || (sel == 3'b111);
  endfunction

endpackage

// File: rtl/dram_ld_unit_ext.sv
// Load data extractor: shifts {hi,lo} right by the byte offset, then sign/zero extends per select.
module dram_ld_ext
  import dram_ld_unit_pkg::*;
(
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic [1:0]  off,
  input  logic [2:0]  sel,
  output logic [31:0] data
);

  logic [31:0] v;

  // hi supplies the upper bytes of a word-crossing access; it is zero for single reads
  assign v = 32'({hi, lo} >> {off, 3'b000});

  always_comb begin
    data = '0;
    case (sel)
      DRAM_RD_B:  data = {{24{v[7]}}, v[7:0]};
      DRAM_RD_BU: data = {24'd0, v[7:0]};
      DRAM_RD_H:  data = {{16{v[15]}}, v[15:0]};
      DRAM_RD_HU: data = {16'd0, v[15:0]};
      DRAM_RD_W:  data = v;
      default:    data = '0;
    endcase
  end

endmodule

// File: rtl/dram_ld_unit.sv
// DRAM load unit: one load at a time, word-aligned reads with hold-until-valid handshake.
// Optional DRAM_LD_SPLIT_EN: word-crossing loads are served by two reads instead of erroring.
module dram_ld_unit
  import dram_ld_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ld_req_i,
  input  logic [2:0]      ld_sel_i,
  input  logic [XLEN-1:0] ld_addr_i,
  output logic            ld_ready_o,
  output logic            ld_valid_o,
  output logic [XLEN-1:0] ld_data_o,
  output logic            ld_err_o,
  output logic            dram_rd_en_o,
  output logic [XLEN-1:0] dram_rd_addr_o,
  input  logic            dram_rd_valid_i,
  input  logic [31:0]     dram_rd_data_i
);

  ld_state_e   state;
  logic [2:0]  sel_q;
  logic [1:0]  off_q;
  logic [31:0] lo_q;
  logic        cross_q;

  logic        req_bad;
  logic        req_cross;
  logic [31:0] ext_hi;
  logic [31:0] ext_lo;
  logic [31:0] ext_data;

  always_comb begin
    req_bad   = sel_is_illegal(ld_sel_i);
    req_cross = 1'b0;
`ifdef DRAM_LD_SPLIT_EN
    req_cross = (sel_is_half(ld_sel_i) && (ld_addr_i[1:0] == 2'd3)) ||
                ((ld_sel_i == DRAM_RD_W) && (ld_addr_i[1:0] != 2'd0));
`else
    if ((sel_is_half(ld_sel_i) && ld_addr_i[0]) ||
        ((ld_sel_i == DRAM_RD_W) && (ld_addr_i[1:0] != 2'd0)))
      req_bad = 1'b1;
`endif
  end

  // Result is extracted from the live read data so ld_valid_o can fire the cycle after it arrives
  always_comb begin
    ext_hi = '0;
    ext_lo = dram_rd_data_i;
    if (state == RD1) begin
      ext_hi = dram_rd_data_i;
      ext_lo = lo_q;
    end
  end

  dram_ld_ext u_ext (
    .hi   (ext_hi),
    .lo   (ext_lo),
    .off  (off_q),
    .sel  (sel_q),
    .data (ext_data)
  );

  assign ld_ready_o = (state == IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      sel_q          <= '0;
      off_q          <= '0;
      lo_q           <= '0;
      cross_q        <= 1'b0;
      ld_valid_o     <= 1'b0;
      ld_data_o      <= '0;
      ld_err_o       <= 1'b0;
      dram_rd_en_o   <= 1'b0;
      dram_rd_addr_o <= '0;
    end else begin
      ld_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_req_i) begin
            sel_q          <= ld_sel_i;
            off_q          <= ld_addr_i[1:0];
            cross_q        <= req_cross;
            dram_rd_addr_o <= {ld_addr_i[XLEN-1:2], 2'b00};
            if (req_bad) begin
              state      <= DONE;
              ld_valid_o <= 1'b1;
              ld_err_o   <= 1'b1;
              ld_data_o  <= '0;
            end else begin
              state        <= RD0;
              dram_rd_en_o <= 1'b1;
            end
          end
        end
        RD0: begin
          if (dram_rd_valid_i) begin
            lo_q <= dram_rd_data_i;
            if (cross_q) begin
              state          <= RD1;
              dram_rd_addr_o <= dram_rd_addr_o + XLEN'(4);
            end else begin
              state        <= DONE;
              dram_rd_en_o <= 1'b0;
              ld_valid_o   <= 1'b1;
              ld_err_o     <= 1'b0;
              ld_data_o    <= ext_data;
            end
          end
        end
        RD1: begin
          if (dram_rd_valid_i) begin
            state        <= DONE;
            dram_rd_en_o <= 1'b0;
            ld_valid_o   <= 1'b1;
            ld_err_o     <= 1'b0;
            ld_data_o    <= ext_data;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_ld_unit.sv
// Directed bench for dram_ld_unit with a small handshaking DRAM responder.
module tb_dram_ld_unit;
  import dram_ld_unit_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ld_req_i = 1'b0;
  logic [2:0]  ld_sel_i = '0;
  logic [31:0] ld_addr_i = '0;
  logic        ld_ready_o;
  logic        ld_valid_o;
  logic [31:0] ld_data_o;
  logic        ld_err_o;
  logic        dram_rd_en_o;
  logic [31:0] dram_rd_addr_o;
  logic        dram_rd_valid_i = 1'b0;
  logic [31:0] dram_rd_data_i = '0;

  int n_checks = 0;
  int n_errors = 0;

  int          lat, en_cnt, extra_valid, ready_bad, stray;
  logic [31:0] r_data, r_addr0, r_addr1, r_hold;
  logic        r_err;

  always #5 clk_i = ~clk_i;

  dram_ld_unit #(.XLEN(32)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ld_req_i       (ld_req_i),
    .ld_sel_i       (ld_sel_i),
    .ld_addr_i      (ld_addr_i),
    .ld_ready_o     (ld_ready_o),
    .ld_valid_o     (ld_valid_o),
    .ld_data_o      (ld_data_o),
    .ld_err_o       (ld_err_o),
    .dram_rd_en_o   (dram_rd_en_o),
    .dram_rd_addr_o (dram_rd_addr_o),
    .dram_rd_valid_i(dram_rd_valid_i),
    .dram_rd_data_i (dram_rd_data_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one load; the responder answers after dly cycles of dram_rd_en_o per read.
  // lat counts cycles from the accepting edge to the ld_valid_o cycle (1 = next cycle).
  task automatic run_load(input logic [2:0] sel, input logic [31:0] addr, input int dly,
                          input logic [31:0] w0, input logic [31:0] w1, input logic busy);
    logic [31:0] base;
    int cyc, rd_wait;
    logic got;
    base = {addr[31:2], 2'b00};
    @(posedge clk_i); #1;
    ld_req_i = 1'b1; ld_sel_i = sel; ld_addr_i = addr;
    @(posedge clk_i); #1;
    ld_req_i = 1'b0;
    cyc = 1; got = 1'b0; rd_wait = 0;
    lat = 99; en_cnt = 0; ready_bad = 0; extra_valid = 0;
    r_addr0 = '0; r_addr1 = '0; r_data = '0; r_err = 1'b0;
    while (!got && cyc < 40) begin
      ld_req_i = 1'b0;
      dram_rd_valid_i = 1'b0;
      if (ld_ready_o) ready_bad++;
      if (ld_valid_o) begin
        got = 1'b1; lat = cyc; r_data = ld_data_o; r_err = ld_err_o;
      end else if (dram_rd_en_o) begin
        en_cnt++;
        if (en_cnt == 1) r_addr0 = dram_rd_addr_o;
        else if (dram_rd_addr_o != r_addr0) r_addr1 = dram_rd_addr_o;
        if (busy) begin ld_req_i = 1'b1; ld_sel_i = 3'b111; end
        if (rd_wait == dly) begin
          dram_rd_valid_i = 1'b1;
          dram_rd_data_i  = (dram_rd_addr_o == base) ? w0 : w1;
          rd_wait = 0;
        end else rd_wait++;
      end
      if (!got) begin @(posedge clk_i); #1; cyc++; end
    end
    dram_rd_valid_i = 1'b0;
    ld_req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      if (ld_valid_o) extra_valid++;
    end
    r_hold = ld_data_o;
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk("rst_ready", 32'(ld_ready_o), 32'd1);
    chk("rst_valid", 32'(ld_valid_o), 32'd0);
    chk("rst_data",  ld_data_o, 32'd0);
    chk("rst_err",   32'(ld_err_o), 32'd0);
    chk("rst_en",    32'(dram_rd_en_o), 32'd0);
    chk("rst_addr",  dram_rd_addr_o, 32'd0);

    run_load(DRAM_RD_B, 32'h1002, 0, 32'h80FF1234, 32'h0, 1'b0);
    chk("lb_lat",   32'(lat), 32'd2);
    chk("lb_data",  r_data, 32'hFFFFFFFF);
    chk("lb_err",   32'(r_err), 32'd0);
    chk("lb_addr",  r_addr0, 32'h1000);
    chk("lb_hold",  r_hold, 32'hFFFFFFFF);

    run_load(DRAM_RD_BU, 32'h1002, 0, 32'h80FF1234, 32'h0, 1'b0);
    chk("lbu_data", r_data, 32'h000000FF);
    chk("lbu_en",   32'(en_cnt), 32'd1);

    run_load(DRAM_RD_HU, 32'h1000, 1, 32'h80FF1234, 32'h0, 1'b0);
    chk("lhu_data", r_data, 32'h00001234);
    chk("lhu_lat",  32'(lat), 32'd3);

    run_load(DRAM_RD_H, 32'h1002, 3, 32'h80FF1234, 32'h0, 1'b1);
    chk("lh_en_cnt", 32'(en_cnt), 32'd4);
    chk("lh_addr",   r_addr0, 32'h1000);
    chk("lh_ready",  32'(ready_bad), 32'd0);
    chk("lh_lat",    32'(lat), 32'd5);
    chk("lh_data",   r_data, 32'hFFFF80FF);
    chk("lh_pulse",  32'(extra_valid), 32'd0);
    chk("lh_idle",   32'(ld_ready_o), 32'd1);

    run_load(DRAM_RD_W, 32'h1001, 0, 32'h44332211, 32'h88776655, 1'b0);
`ifdef DRAM_LD_SPLIT_EN
    chk("lw_split_en",   32'(en_cnt), 32'd2);
    chk("lw_split_a0",   r_addr0, 32'h1000);
    chk("lw_split_a1",   r_addr1, 32'h1004);
    chk("lw_split_data", r_data, 32'h55443322);
    chk("lw_split_err",  32'(r_err), 32'd0);
    chk("lw_split_lat",  32'(lat), 32'd3);
`else
    chk("lw_mis_en",   32'(en_cnt), 32'd0);
    chk("lw_mis_lat",  32'(lat), 32'd1);
    chk("lw_mis_err",  32'(r_err), 32'd1);
    chk("lw_mis_data", r_data, 32'd0);
`endif

    run_load(3'b111, 32'h1000, 0, 32'h12345678, 32'h0, 1'b0);
    chk("ill_en",    32'(en_cnt), 32'd0);
    chk("ill_lat",   32'(lat), 32'd1);
    chk("ill_err",   32'(r_err), 32'd1);
    chk("ill_data",  r_data, 32'd0);
    chk("ill_pulse", 32'(extra_valid), 32'd0);

    // Reset while the unit is waiting in RD0
    @(posedge clk_i); #1;
    ld_req_i = 1'b1; ld_sel_i = DRAM_RD_W; ld_addr_i = 32'h3000;
    @(posedge clk_i); #1;
    ld_req_i = 1'b0;
    chk("rd0_en", 32'(dram_rd_en_o), 32'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("mid_rst_en",    32'(dram_rd_en_o), 32'd0);
    chk("mid_rst_ready", 32'(ld_ready_o), 32'd1);
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      if (ld_valid_o) stray++;
      @(posedge clk_i); #1;
    end
    chk("mid_rst_valid", 32'(stray), 32'd0);

    run_load(DRAM_RD_W, 32'h2000, 0, 32'hDEADBEEF, 32'h0, 1'b0);
    chk("lw_data", r_data, 32'hDEADBEEF);
    chk("lw_err",  32'(r_err), 32'd0);
    chk("lw_addr", r_addr0, 32'h2000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dram_ld_unit.md
Name: dram_ld_unit

Overview:
Load-side counterpart to the store byte-enable logic in the hxd32 MEM stage. Accepts one load request from the pipeline and issues word-aligned reads to the data RAM over a hold-until-valid handshake. Selects the addressed byte/half/word, applies sign or zero extension and returns an XLEN result with a one-cycle valid pulse. Sits between the MEM stage and the DRAM read port; the pipeline stalls while ld_ready_o is low.

Parameters:
XLEN, 32, datapath and address width; only 32 is supported.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
ld_req_i  in  1  load request, sampled only when ld_ready_o=1
ld_sel_i  in  3  load type: DRAM_RD_B/H/W/BU/HU
ld_addr_i  in  XLEN  byte address
ld_ready_o  out  1  unit idle and able to accept a request
ld_valid_o  out  1  one-cycle pulse: result and error are valid
ld_data_o  out  XLEN  extended load result
ld_err_o  out  1  misaligned or illegal select; qualified by ld_valid_o
dram_rd_en_o  out  1  read request; held high until accepted
dram_rd_addr_o  out  XLEN  word address, bits [1:0] always 0
dram_rd_valid_i  in  1  data present for the held request this cycle
dram_rd_data_i  in  32  read data

Behaviour:
- Interface: one clock, clk_i; rst_i is synchronous and active-high.
- Reset: state IDLE. ld_valid_o, ld_data_o, ld_err_o, dram_rd_en_o and dram_rd_addr_o are all 0. ld_ready_o=1 from the first cycle after reset.
- FSM states: IDLE, RD0, RD1, DONE. ld_ready_o=1 only in IDLE. All other outputs are registered.
- IDLE, on ld_req_i=1:
  - capture sel and off=addr[1:0]; dram_rd_addr_o <= {addr[31:2],2'b00}.
  - illegal sel (011, 110, 111) or misaligned (H/HU with off[0]=1; W with off!=0): go to DONE with err=1 and data=0. No DRAM access.
  - otherwise: go to RD0 and set dram_rd_en_o=1.
- RD0: dram_rd_en_o stays high and the address stays stable until dram_rd_valid_i=1. In that cycle: lo <= dram_rd_data_i, dram_rd_en_o <= 0, go to DONE (or RD1 under the split feature).
- RD1 (feature only): same handshake at address +4, capturing hi, then go to DONE.
- DONE: ld_valid_o=1 for exactly one cycle, then IDLE. ld_data_o and ld_err_o hold their values until the next DONE.
- Extraction: v = {hi,lo} >> (8*off), with hi=0 when no second read.
  - B: sign-extend v[7:0]. BU: zero-extend v[7:0].
  - H: sign-extend v[15:0]. HU: zero-extend v[15:0].
  - W: v[31:0].
- Minimum latency: request accepted in cycle N, dram_rd_en_o high in N+1; with valid in N+1, ld_valid_o fires in N+2. Error-only path: ld_valid_o in N+1.
- ld_req_i while ld_ready_o=0 is ignored; no queueing.
- dram_rd_valid_i outside RD0/RD1 is ignored.
- Reset mid-operation: the transaction is abandoned, dram_rd_en_o is 0 the next cycle, and no ld_valid_o is produced.

Optional Feature:
Macro DRAM_LD_SPLIT_EN.
- Defined: word-crossing accesses perform two reads (RD0 at A, RD1 at A+4) and return the merged result with err=0. Crossing cases are H/HU with off=3, and W with off=1,2,3. H/HU with off=1 is served by one read.
- Not defined: RD1 does not exist, and every misaligned access (H/HU with off[0]=1; W with off!=0) returns err=1 and data=0.

Decomposition:
- Shared package holds the ld_sel encodings, matching funct3: DRAM_RD_B=3'b000, DRAM_RD_H=3'b001, DRAM_RD_W=3'b010, DRAM_RD_BU=3'b100, DRAM_RD_HU=3'b101. It also holds the FSM state enum.
- One combinational sub-module, dram_ld_ext, performs shift and extension from {hi,lo}, off and sel to XLEN data; it is reused by the DONE register.

Test Plan:
- LB at 0x1002, memory word 0x80FF1234, valid on the first RD0 cycle -> ld_valid_o 2 cycles after request, data 0xFFFFFFFF. LBU at the same address -> 0x000000FF.
- LH at 0x1002, word 0x80FF1234, dram_rd_valid_i delayed 3 cycles -> dram_rd_en_o held 4 cycles at address 0x1000, ld_ready_o=0 throughout, data 0xFFFF80FF, one-cycle ld_valid_o.
- LW at 0x1001:
  - without DRAM_LD_SPLIT_EN -> no dram_rd_en_o, ld_valid_o next cycle with err=1, data=0.
  - with the macro, words 0x44332211 at 0x1000 and 0x88776655 at 0x1004 -> reads at 0x1000 then 0x1004, data 0x55443322, err=0.
- Illegal sel 3'b111 at 0x1000 -> err=1, data=0, no DRAM access. A ld_req_i asserted while busy is ignored and produces no extra ld_valid_o.
- rst_i asserted while in RD0 -> dram_rd_en_o=0 and ld_ready_o=1 the next cycle, no ld_valid_o. A following LW at 0x2000 with word 0xDEADBEEF -> data 0xDEADBEEF.
